// File: rtl/lsu_mem.sv
// Load/store unit: req/ack handshake to data memory, big-endian byte enables,
// load alignment/extension, and misalignment detection without issuing.
module lsu_mem #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       GPR_busB_reg,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;

  logic        mis_c;
  logic        we_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_c;

  assign we_c = (op >= OP_SW);

  // Request-side decode from the live controller inputs, used only in IDLE.
  always_comb begin
    mis_c   = 1'b0;
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    case (op)
      OP_LW, OP_SW: begin
        mis_c = (addr[1:0] != 2'b00);
        be_c  = 4'b1111;
      end
      OP_LH, OP_LHU, OP_SH: begin
        mis_c = addr[0];
        be_c  = addr[1] ? 4'b0011 : 4'b1100;
      end
      default: be_c = 4'b1000 >> addr[1:0];
    endcase
    case (op)
      OP_SW:   wdata_c = GPR_busB_reg;
      OP_SH:   wdata_c = {GPR_busB_reg[15:0], GPR_busB_reg[15:0]};
      OP_SB:   wdata_c = {4{GPR_busB_reg[7:0]}};
      default: wdata_c = 32'h0;
    endcase
  end

  // Lane select is big-endian: offset 0 lives in the top byte.
  always_comb begin
    byte_sel = 8'h0;
    case (off_q)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    ld_c     = mem_rdata;
    case (op_q)
      OP_LH:   ld_c = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_c = {16'h0, half_sel};
      OP_LB:   ld_c = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_c = {24'h0, byte_sel};
      default: ld_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 3'b000;
      off_q     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      load_data <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            off_q <= addr[1:0];
            busy  <= 1'b1;
            if (mis_c) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= we_c;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            if (!mem_we) load_data <= ld_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: stores, loads, misalignment, ignored starts, reset mid-request.
module tb_lsu_mem;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] GPR_busB_reg;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks;
  int errors;

  lsu_mem #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
    .GPR_busB_reg(GPR_busB_reg), .busy(busy), .done(done), .misalign(misalign),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0;
    GPR_busB_reg = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    step(); step();
    checks++;
    if ({busy, done, misalign, mem_req, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, misalign, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got addr=%h be=%b wd=%h ld=%h want zeros", mem_addr, mem_be, mem_wdata, load_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sw();
    int req_cycles;
    op = 3'b101; addr = 32'h0000_1004; GPR_busB_reg = 32'hDEAD_BEEF; mem_ack = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (mem_addr !== 32'h1004 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF || mem_we !== 1'b1) begin
      errors++; $display("FAIL sw_req got addr=%h be=%b wd=%h we=%b want 1004 1111 deadbeef 1", mem_addr, mem_be, mem_wdata, mem_we);
    end
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1 && done === 1'b0 && mem_addr === 32'h1004) req_cycles++;
      if (i == 2) mem_ack = 1'b1;
      if (i < 2) step();
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (req_cycles !== 3) begin
      errors++; $display("FAIL sw_req_len got %0d want 3", req_cycles);
    end
    checks++;
    if (done !== 1'b1 || mem_req !== 1'b0 || misalign !== 1'b0 || load_data !== 32'h0) begin
      errors++; $display("FAIL sw_done got done=%b req=%b mis=%b ld=%h want 1 0 0 0", done, mem_req, misalign, load_data);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sw_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sb();
    op = 3'b111; addr = 32'h0000_2001; GPR_busB_reg = 32'h0000_00A5; mem_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || done !== 1'b0 || mem_addr !== 32'h2000 || mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_req got req=%b done=%b addr=%h be=%b wd=%h want 1 0 2000 0100 a5a5a5a5",
                         mem_req, done, mem_addr, mem_be, mem_wdata);
    end
    step();
    checks++;
    if (done !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sb_done got done=%b req=%b want 1 0", done, mem_req);
    end
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  t_op [6] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b011, 3'b000};
    logic [1:0]  t_off[6] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [3:0]  t_be [6] = '{4'b0001, 4'b0001, 4'b1100, 4'b0011, 4'b1000, 4'b1111};
    logic [31:0] t_ld [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_1234,
                              32'h0000_56F0, 32'h0000_0012, 32'h1234_56F0};
    mem_rdata = 32'h1234_56F0; mem_ack = 1'b1; GPR_busB_reg = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      op = t_op[i]; addr = {30'h0000_0C00, t_off[i]};
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (mem_be !== t_be[i] || mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_addr !== 32'h3000) begin
        errors++; $display("FAIL load%0d_req got be=%b we=%b wd=%h addr=%h want %b 0 0 3000",
                           i, mem_be, mem_we, mem_wdata, mem_addr, t_be[i]);
      end
      step();
      checks++;
      if (done !== 1'b1 || load_data !== t_ld[i]) begin
        errors++; $display("FAIL load%0d_data got done=%b ld=%h want 1 %h", i, done, load_data, t_ld[i]);
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    logic [2:0]  t_op [3] = '{3'b010, 3'b101, 3'b110};
    logic [31:0] t_ad [3] = '{32'h0000_4003, 32'h0000_4002, 32'h0000_4001};
    int req_seen;
    for (int i = 0; i < 3; i++) begin
      req_seen = 0;
      op = t_op[i]; addr = t_ad[i];
      start = 1'b1;
      step();
      start = 1'b0;
      if (mem_req) req_seen++;
      checks++;
      if (done !== 1'b1 || misalign !== 1'b1 || busy !== 1'b1 || load_data !== 32'h1234_56F0) begin
        errors++; $display("FAIL mis%0d_resp got done=%b mis=%b busy=%b ld=%h want 1 1 1 123456f0",
                           i, done, misalign, busy, load_data);
      end
      step();
      if (mem_req) req_seen++;
      checks++;
      if (done !== 1'b0 || misalign !== 1'b0 || busy !== 1'b0 || req_seen !== 0) begin
        errors++; $display("FAIL mis%0d_after got done=%b mis=%b busy=%b reqs=%0d want 0 0 0 0",
                           i, done, misalign, busy, req_seen);
      end
    end
  endtask

  task automatic test_ignored_start();
    int done_cnt;
    int req_cnt;
    done_cnt = 0; req_cnt = 0;
    op = 3'b101; addr = 32'h0000_0040; GPR_busB_reg = 32'h0102_0304; mem_ack = 1'b0;
    start = 1'b1;
    step();
    op = 3'b111; addr = 32'h0000_0080;
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    if (done) done_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) done_cnt++;
      if (mem_req) req_cnt++;
      step();
    end
    checks++;
    if (done_cnt !== 1 || req_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ignored_start got dones=%0d reqs=%0d busy=%b want 1 0 0", done_cnt, req_cnt, busy);
    end
    checks++;
    if (mem_addr !== 32'h0040 || mem_be !== 4'b1111) begin
      errors++; $display("FAIL ignored_addr got addr=%h be=%b want 40 1111", mem_addr, mem_be);
    end
  endtask

  task automatic test_reset_mid_req();
    int done_cnt;
    done_cnt = 0;
    op = 3'b000; addr = 32'h0000_0050; mem_ack = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstreq_pre got req=%b want 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'h0 || done !== 1'b0) begin
      errors++; $display("FAIL rstreq_async got req=%b busy=%b ld=%h done=%b want 0 0 0 0",
                         mem_req, busy, load_data, done);
    end
    mem_ack = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done || mem_req) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL rstreq_stale_ack got activity=%0d want 0", done_cnt);
    end
    mem_rdata = 32'hCAFE_F00D;
    op = 3'b000; addr = 32'h0000_0060;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0060) begin
      errors++; $display("FAIL rstreq_lw_req got req=%b addr=%h want 1 60", mem_req, mem_addr);
    end
    step();
    checks++;
    if (done !== 1'b1 || load_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rstreq_lw_done got done=%b ld=%h want 1 cafef00d", done, load_data);
    end
    mem_ack = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_misalign();
    test_ignored_start();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
